// File: rtl/pipeline_hazard_controller_if.sv
// Signal bundle between the five-stage pipeline datapath and its hazard controller.
// The datapath uses the master view and the controller uses the slave view.
interface pipeline_hazard_controller_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       RsD, RtD, RsE, RtE;
    logic [4:0]       WriteRegE, WriteRegM, WriteRegW;
    logic             RegWriteE, RegWriteM, RegWriteW;
    logic             MemtoRegE, MemtoRegM, MemWriteM;
    logic             BranchM, ZeroFlagM;
    logic             dmem_ready;
    logic             dmem_req;
    logic             PCSrcM;
    logic             StallF, StallD, StallE, StallM;
    logic             FlushD, FlushE, FlushM, FlushW;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             mem_error;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
               RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, MemWriteM,
               BranchM, ZeroFlagM, dmem_ready,
        input  dmem_req, PCSrcM, StallF, StallD, StallE, StallM,
               FlushD, FlushE, FlushM, FlushW, ForwardAE, ForwardBE,
               mem_error, stall_cycles
    );

    modport slave (
        input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
               RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, MemWriteM,
               BranchM, ZeroFlagM, dmem_ready,
        output dmem_req, PCSrcM, StallF, StallD, StallE, StallM,
               FlushD, FlushE, FlushM, FlushW, ForwardAE, ForwardBE,
               mem_error, stall_cycles
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Hazard sequencer for the five-stage pipeline: load-use and branch stalls/flushes,
// Execute-stage operand forwarding, data-memory wait-state FSM and stall-cycle counter.
module pipeline_hazard_controller #(
    parameter int TIMEOUT = 8,
    parameter int CNT_W   = 16
) (
    input logic                          clk,
    input logic                          reset,
    pipeline_hazard_controller_if.slave  hz
);
    typedef enum logic [1:0] {IDLE, WAIT, ERROR} state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t           state_q, state_d;
    logic [7:0]       wcnt_q, wcnt_d;
    logic             mem_error_q, mem_error_d;
    logic [CNT_W-1:0] stall_cnt_q;

    logic memop, memstall, lwstall, branch_taken, stall_f;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) return v;
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Memory stage wins over Writeback because it holds the younger result.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic       rw_m, input logic [4:0] wr_m,
                                           input logic       rw_w, input logic [4:0] wr_w);
        if (rw_m && (wr_m != 5'd0) && (wr_m == src)) return 2'b10;
        if (rw_w && (wr_w != 5'd0) && (wr_w == src)) return 2'b01;
        return 2'b00;
    endfunction

    assign memop        = hz.MemtoRegM | hz.MemWriteM;
    assign branch_taken = hz.BranchM & hz.ZeroFlagM;
    assign lwstall      = hz.MemtoRegE & hz.RegWriteE & (hz.WriteRegE != 5'd0) &
                          ((hz.WriteRegE == hz.RsD) | (hz.WriteRegE == hz.RtD));
    assign memstall     = (state_q == ERROR) ? 1'b1 : (memop & ~hz.dmem_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wcnt_q      <= 8'd0;
            mem_error_q <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            mem_error_q <= mem_error_d;
            if (stall_f) stall_cnt_q <= sat_inc(stall_cnt_q);
        end
    end

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        mem_error_d = mem_error_q;
        case (state_q)
            IDLE: begin
                if (memop && !hz.dmem_ready) begin
                    state_d = WAIT;
                    wcnt_d  = 8'd1;
                end
            end
            WAIT: begin
                if (hz.dmem_ready) begin
                    state_d = IDLE;
                    wcnt_d  = 8'd0;
                end else if (wcnt_q == TIMEOUT_C) begin
                    state_d     = ERROR;
                    mem_error_d = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            ERROR:   state_d = ERROR;
            default: state_d = IDLE;
        endcase
    end

    // Every output is held at zero while reset is asserted, even mid-cycle.
    always_comb begin
        hz.dmem_req  = 1'b0;
        hz.PCSrcM    = 1'b0;
        hz.StallF    = 1'b0;
        hz.StallD    = 1'b0;
        hz.StallE    = 1'b0;
        hz.StallM    = 1'b0;
        hz.FlushD    = 1'b0;
        hz.FlushE    = 1'b0;
        hz.FlushM    = 1'b0;
        hz.FlushW    = 1'b0;
        hz.ForwardAE = 2'b00;
        hz.ForwardBE = 2'b00;
        if (!reset) begin
            hz.dmem_req = memop & (state_q != ERROR);
            if (memstall) begin
                hz.StallF = 1'b1;
                hz.StallD = 1'b1;
                hz.StallE = 1'b1;
                hz.StallM = 1'b1;
                hz.FlushW = 1'b1;
            end else begin
                hz.PCSrcM    = branch_taken;
                hz.StallF    = lwstall & ~branch_taken;
                hz.StallD    = lwstall & ~branch_taken;
                hz.FlushE    = lwstall | branch_taken;
                hz.FlushD    = branch_taken;
                hz.FlushM    = branch_taken;
                hz.ForwardAE = fwd_sel(hz.RsE, hz.RegWriteM, hz.WriteRegM, hz.RegWriteW, hz.WriteRegW);
                hz.ForwardBE = fwd_sel(hz.RtE, hz.RegWriteM, hz.WriteRegM, hz.RegWriteW, hz.WriteRegW);
            end
        end
    end

    assign stall_f         = hz.StallF;
    assign hz.mem_error    = mem_error_q;
    assign hz.stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller with a 4-bit stall counter and TIMEOUT of 8.
module tb_pipeline_hazard_controller;
    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 8;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    pipeline_hazard_controller_if #(.CNT_W(CNT_W)) hz ();

    pipeline_hazard_controller #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hz.RsD = 5'd0; hz.RtD = 5'd0; hz.RsE = 5'd0; hz.RtE = 5'd0;
        hz.WriteRegE = 5'd0; hz.WriteRegM = 5'd0; hz.WriteRegW = 5'd0;
        hz.RegWriteE = 1'b0; hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
        hz.MemtoRegE = 1'b0; hz.MemtoRegM = 1'b0; hz.MemWriteM = 1'b0;
        hz.BranchM = 1'b0; hz.ZeroFlagM = 1'b0; hz.dmem_ready = 1'b0;
    endtask

    function automatic logic [31:0] all_outs();
        return {17'd0, hz.dmem_req, hz.PCSrcM, hz.StallF, hz.StallD, hz.StallE, hz.StallM,
                hz.FlushD, hz.FlushE, hz.FlushM, hz.FlushW, hz.ForwardAE, hz.ForwardBE, hz.mem_error};
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        clear_inputs();

        // Outputs stay low under reset even with a memop and a taken branch present
        hz.MemtoRegM = 1'b1; hz.BranchM = 1'b1; hz.ZeroFlagM = 1'b1;
        #3;
        chk("reset_outs", all_outs(), 32'd0);
        chk("reset_cnt", 32'(hz.stall_cycles), 32'd0);
        clear_inputs();
        #3;
        reset = 1'b0;
        #1;
        chk("idle_outs", all_outs(), 32'd0);

        // Load-use on RsD
        tick();
        hz.MemtoRegE = 1'b1; hz.RegWriteE = 1'b1; hz.WriteRegE = 5'd8; hz.RsD = 5'd8; hz.RtD = 5'd3;
        #1;
        chk("lw_stallF", 32'(hz.StallF), 32'd1);
        chk("lw_stallD", 32'(hz.StallD), 32'd1);
        chk("lw_flushE", 32'(hz.FlushE), 32'd1);
        chk("lw_flushD", 32'(hz.FlushD), 32'd0);
        chk("lw_stallE", 32'(hz.StallE), 32'd0);
        tick();
        chk("lw_cnt", 32'(hz.stall_cycles), 32'd1);
        // Load-use on RtD
        hz.RsD = 5'd1; hz.RtD = 5'd8;
        #1;
        chk("lw_rt_stallF", 32'(hz.StallF), 32'd1);
        // Register zero never creates a hazard
        hz.WriteRegE = 5'd0; hz.RsD = 5'd0; hz.RtD = 5'd0;
        #1;
        chk("lw_r0_stallF", 32'(hz.StallF), 32'd0);
        chk("lw_r0_flushE", 32'(hz.FlushE), 32'd0);
        tick();
        chk("lw_cnt_hold", 32'(hz.stall_cycles), 32'd1);
        clear_inputs();

        // Forwarding priority
        hz.RegWriteM = 1'b1; hz.RegWriteW = 1'b1; hz.WriteRegM = 5'd5; hz.WriteRegW = 5'd5;
        hz.RsE = 5'd5; hz.RtE = 5'd5;
        #1;
        chk("fwdA_mem", 32'(hz.ForwardAE), 32'd2);
        chk("fwdB_mem", 32'(hz.ForwardBE), 32'd2);
        hz.RegWriteM = 1'b0;
        #1;
        chk("fwdA_wb", 32'(hz.ForwardAE), 32'd1);
        hz.RtE = 5'd6;
        #1;
        chk("fwdB_none", 32'(hz.ForwardBE), 32'd0);
        hz.WriteRegW = 5'd0; hz.RsE = 5'd0;
        #1;
        chk("fwdA_r0", 32'(hz.ForwardAE), 32'd0);
        clear_inputs();

        // Taken branch overrides simultaneous load-use
        hz.MemtoRegE = 1'b1; hz.RegWriteE = 1'b1; hz.WriteRegE = 5'd8; hz.RsD = 5'd8;
        hz.BranchM = 1'b1; hz.ZeroFlagM = 1'b1;
        #1;
        chk("br_pcsrc", 32'(hz.PCSrcM), 32'd1);
        chk("br_flushD", 32'(hz.FlushD), 32'd1);
        chk("br_flushE", 32'(hz.FlushE), 32'd1);
        chk("br_flushM", 32'(hz.FlushM), 32'd1);
        chk("br_stallF", 32'(hz.StallF), 32'd0);
        chk("br_stallD", 32'(hz.StallD), 32'd0);
        tick();
        chk("br_cnt", 32'(hz.stall_cycles), 32'd1);
        clear_inputs();

        // Memory wait of three cycles; forwarding suppressed during the stall
        hz.MemtoRegM = 1'b1; hz.dmem_ready = 1'b0;
        hz.RegWriteM = 1'b1; hz.WriteRegM = 5'd7; hz.RsE = 5'd7;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mw_stallF", 32'(hz.StallF), 32'd1);
            chk("mw_stallM", 32'(hz.StallM), 32'd1);
            chk("mw_flushW", 32'(hz.FlushW), 32'd1);
            chk("mw_req", 32'(hz.dmem_req), 32'd1);
            chk("mw_fwdA", 32'(hz.ForwardAE), 32'd0);
            tick();
        end
        hz.dmem_ready = 1'b1;
        #1;
        chk("mw_done_stallF", 32'(hz.StallF), 32'd0);
        chk("mw_done_flushW", 32'(hz.FlushW), 32'd0);
        chk("mw_done_req", 32'(hz.dmem_req), 32'd1);
        chk("mw_done_fwdA", 32'(hz.ForwardAE), 32'd2);
        tick();
        chk("mw_cnt", 32'(hz.stall_cycles), 32'd4);
        #1;
        chk("mw_single", 32'(hz.StallF), 32'd0);
        clear_inputs();

        // Store times out: one IDLE stall cycle plus eight WAIT cycles
        hz.MemWriteM = 1'b1; hz.dmem_ready = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("to_wait_err", 32'(hz.mem_error), 32'd0);
        chk("to_wait_cnt", 32'(hz.stall_cycles), 32'd12);
        chk("to_wait_req", 32'(hz.dmem_req), 32'd1);
        tick();
        chk("to_err", 32'(hz.mem_error), 32'd1);
        chk("to_err_cnt", 32'(hz.stall_cycles), 32'd13);
        chk("to_err_req", 32'(hz.dmem_req), 32'd0);
        chk("to_err_stallE", 32'(hz.StallE), 32'd1);
        chk("to_err_flushW", 32'(hz.FlushW), 32'd1);
        // ERROR holds stalls even once memory answers
        hz.dmem_ready = 1'b1;
        #1;
        chk("to_err_sticky_stallF", 32'(hz.StallF), 32'd1);
        tick();
        chk("sat_14", 32'(hz.stall_cycles), 32'd14);
        tick();
        chk("sat_15", 32'(hz.stall_cycles), 32'd15);
        for (int i = 0; i < 6; i++) tick();
        chk("sat_hold", 32'(hz.stall_cycles), 32'd15);
        chk("err_hold", 32'(hz.mem_error), 32'd1);

        // Asynchronous reset between clock edges with a memop pending
        hz.dmem_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("areset_outs", all_outs(), 32'd0);
        chk("areset_cnt", 32'(hz.stall_cycles), 32'd0);
        #1;
        reset = 1'b0;
        #1;
        chk("post_reset_req", 32'(hz.dmem_req), 32'd1);
        chk("post_reset_err", 32'(hz.mem_error), 32'd0);
        hz.dmem_ready = 1'b1;
        #1;
        chk("post_reset_idle", 32'(hz.StallF), 32'd0);
        clear_inputs();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, observed=running expected=finished");
        $fatal(1, "bench time limit reached");
    end
endmodule
